// File: rtl/controlador_multiplexor_display.sv
// controlador_multiplexor_display
//
// This module scans NUM_DIG common-anode digits so that they can share one
// binary-to-hex seven-segment decoder. Each digit slot lasts DIV cycles. The
// first GUARD cycles of a slot are blanked to prevent ghosting, and the digit
// is lit for the remaining cycles.
//
// New values enter through a double buffer. A value loaded with 'cargar' is
// held in a shadow register. It is copied to the display register only at a
// frame boundary, or at any cycle while the scan is idle, so the display
// never tears.
//
// Parameters:
//   NUM_DIG  number of digits; digit NUM_DIG-1 is the most significant
//   DIV      cycles per digit slot (>= 2)
//   GUARD    blanked cycles at the start of each slot (0..DIV-1)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   habilitar  scan enable
//   dato       value to display; nibble k drives digit k
//   cargar     one-cycle strobe that captures dato
//   nibble     digit code for the shared decoder (registered)
//   an         anode enables, active-low (registered)
//   listo      one-cycle pulse; the edge that raises it also commits the new
//              display value
//   fin_trama  one-cycle pulse registered off the last cycle of digit
//              NUM_DIG-1; it coincides with a commit-driven listo
//
// Optional feature:
//   SUPRIMIR_CEROS_EN  when defined, leading-zero digits (k > 0) stay dark
//                      during their lit phase; digit 0 is always lit.

module controlador_multiplexor_display #(
    parameter int unsigned NUM_DIG = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned GUARD   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   habilitar,
    input  logic [4*NUM_DIG-1:0]   dato,
    input  logic                   cargar,
    output logic [3:0]             nibble,
    output logic [NUM_DIG-1:0]     an,
    output logic                   listo,
    output logic                   fin_trama
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_FIN = (GUARD == 0) ? '0 : CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        GUARDA = 2'd1,
        ACTIVO = 2'd2
    } estado_t;

    estado_t               r_estado, w_estado_sig;
    logic [CW-1:0]         r_cnt, w_cnt_sig;
    logic [IW-1:0]         r_idx, w_idx_sig;
    logic [4*NUM_DIG-1:0]  r_sombra, w_sombra_sig;
    logic [4*NUM_DIG-1:0]  r_pantalla, w_pantalla_sig;
    logic                  r_pendiente, w_pendiente_sig;
    logic [3:0]            r_nibble, w_nibble_sig;
    logic [NUM_DIG-1:0]    r_an, w_an_sig;
    logic                  r_listo, r_fin_trama;

    logic                  w_ultimo;
    logic                  w_trama;
    logic                  w_ventana;
    logic                  w_commit;

    // Last cycle of the slot, and last cycle of the whole frame.
    always_comb begin
        w_ultimo = (r_cnt == CNT_MAX);
        w_trama  = (r_estado == ACTIVO) && w_ultimo && (r_idx == IDX_MAX);
    end

    // Next state of the scan: slot counter, digit index and phase.
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_idx_sig    = r_idx;

        if (!habilitar) begin
            w_estado_sig = REPOSO;
            w_cnt_sig    = '0;
            w_idx_sig    = '0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    w_cnt_sig    = '0;
                    w_idx_sig    = '0;
                    w_estado_sig = (GUARD == 0) ? ACTIVO : GUARDA;
                end
                GUARDA: begin
                    // The counter runs across the whole slot, so the lit
                    // phase starts counting from GUARD.
                    w_cnt_sig = r_cnt + 1'b1;
                    if (r_cnt == GUARD_FIN) begin
                        w_estado_sig = ACTIVO;
                    end
                end
                ACTIVO: begin
                    if (w_ultimo) begin
                        w_cnt_sig    = '0;
                        w_idx_sig    = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
                        w_estado_sig = (GUARD == 0) ? ACTIVO : GUARDA;
                    end else begin
                        w_cnt_sig = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_estado_sig = REPOSO;
                    w_cnt_sig    = '0;
                    w_idx_sig    = '0;
                end
            endcase
        end
    end

    // Double buffer. Idle cycles and the frame's last cycle are commit
    // windows. A strobe landing in a window bypasses the shadow register.
    always_comb begin
        w_ventana       = (r_estado == REPOSO) || w_trama;
        w_commit        = w_ventana && (r_pendiente || cargar);
        w_sombra_sig    = cargar ? dato : r_sombra;
        w_pendiente_sig = r_pendiente;
        w_pantalla_sig  = r_pantalla;
        if (w_commit) begin
            w_pendiente_sig = 1'b0;
            w_pantalla_sig  = cargar ? dato : r_sombra;
        end else if (cargar) begin
            w_pendiente_sig = 1'b1;
        end
    end

`ifdef SUPRIMIR_CEROS_EN
    // w_ceros[k] is set when digits NUM_DIG-1 down to k are all zero.
    logic [NUM_DIG-1:0] w_ceros;

    always_comb begin
        logic        acum;
        int unsigned k;
        w_ceros = '0;
        acum    = 1'b1;
        for (int unsigned j = 0; j < NUM_DIG; j++) begin
            k          = NUM_DIG - 1 - j;
            acum       = acum && (w_pantalla_sig[4*k +: 4] == 4'h0);
            w_ceros[k] = acum;
        end
    end
`endif

    // Outputs are decoded from next-state values so that the registered pins
    // stay aligned with the scan state they describe.
    always_comb begin
        w_nibble_sig = w_pantalla_sig[4*w_idx_sig +: 4];
        w_an_sig     = '1;
        if (w_estado_sig == ACTIVO) begin
`ifdef SUPRIMIR_CEROS_EN
            if ((w_idx_sig == '0) || !w_ceros[w_idx_sig]) begin
                w_an_sig[w_idx_sig] = 1'b0;
            end
`else
            w_an_sig[w_idx_sig] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado    <= REPOSO;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sombra    <= '0;
            r_pantalla  <= '0;
            r_pendiente <= 1'b0;
            r_nibble    <= '0;
            r_an        <= '1;
            r_listo     <= 1'b0;
            r_fin_trama <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_cnt       <= w_cnt_sig;
            r_idx       <= w_idx_sig;
            r_sombra    <= w_sombra_sig;
            r_pantalla  <= w_pantalla_sig;
            r_pendiente <= w_pendiente_sig;
            r_nibble    <= w_nibble_sig;
            r_an        <= w_an_sig;
            r_listo     <= w_commit;
            r_fin_trama <= w_trama;
        end
    end

    assign nibble    = r_nibble;
    assign an        = r_an;
    assign listo     = r_listo;
    assign fin_trama = r_fin_trama;

endmodule

// File: tb/tb_controlador_multiplexor_display.sv
module tb_controlador_multiplexor_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilitar;
    logic [15:0] dato;
    logic        cargar;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        listo;
    logic        fin_trama;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    controlador_multiplexor_display #(
        .NUM_DIG (4),
        .DIV     (8),
        .GUARD   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .habilitar (habilitar),
        .dato      (dato),
        .cargar    (cargar),
        .nibble    (nibble),
        .an        (an),
        .listo     (listo),
        .fin_trama (fin_trama)
    );

    // Expected anode patterns in each digit's lit phase, digit 0 in bits [3:0].
    localparam logic [15:0] AN_TODOS = 16'h7BDE;
`ifdef SUPRIMIR_CEROS_EN
    localparam logic [15:0] AN_00FF = 16'hFFDE;
    localparam logic [15:0] AN_0005 = 16'hFFFE;
    localparam logic [3:0]  AN_D2_00FF = 4'hF;
    localparam logic [3:0]  AN_D1_0000 = 4'hF;
`else
    localparam logic [15:0] AN_00FF = 16'h7BDE;
    localparam logic [15:0] AN_0005 = 16'h7BDE;
    localparam logic [3:0]  AN_D2_00FF = 4'hB;
    localparam logic [3:0]  AN_D1_0000 = 4'hD;
`endif

    task automatic comprobar(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        n_vec++;
        assert (obs === esp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic avanzar(input int unsigned n);
        repeat (n) paso();
    endtask

    // Called at frame position 2 (digit 0 lit); checks each digit's lit phase
    // and returns at frame position 26.
    task automatic revisar_trama(input string tag, input logic [15:0] val, input logic [15:0] an_esp);
        logic [3:0] nib_esp;
        logic [3:0] an_d;
        for (int unsigned d = 0; d < 4; d++) begin
            if (d != 0) avanzar(8);
            nib_esp = val[4*d +: 4];
            an_d    = an_esp[4*d +: 4];
            comprobar($sformatf("%s_nib_d%0d", tag, d), {12'h0, nibble}, {12'h0, nib_esp});
            comprobar($sformatf("%s_an_d%0d", tag, d), {12'h0, an}, {12'h0, an_d});
        end
    endtask

    initial begin
        rst       = 1'b1;
        habilitar = 1'b0;
        cargar    = 1'b0;
        dato      = '0;
        avanzar(2);
        rst = 1'b0;
        comprobar("rst_an", {12'h0, an}, 16'h000F);
        comprobar("rst_nibble", {12'h0, nibble}, 16'h0000);
        comprobar("rst_listo", {15'h0, listo}, 16'h0000);
        comprobar("rst_fin", {15'h0, fin_trama}, 16'h0000);

        // Slot timing: 2 blanked, 6 lit, 2 blanked, then digit 1.
        habilitar = 1'b1;
        for (int unsigned c = 0; c < 11; c++) begin
            logic [3:0] e;
            paso();
            e = (c < 2) ? 4'hF : (c < 8) ? 4'hE : (c < 10) ? 4'hF : 4'hD;
            comprobar($sformatf("scan_an_c%0d", c), {12'h0, an}, {12'h0, e});
            comprobar($sformatf("scan_nib_c%0d", c), {12'h0, nibble}, 16'h0000);
        end

        // Mid-frame load at position 10, held until the frame wraps.
        dato   = 16'h1A2F;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("mid_listo", {15'h0, listo}, 16'h0000);
        comprobar("mid_nib", {12'h0, nibble}, 16'h0000);
        avanzar(20);
        comprobar("prewrap_listo", {15'h0, listo}, 16'h0000);
        comprobar("prewrap_fin", {15'h0, fin_trama}, 16'h0000);
        comprobar("prewrap_nib", {12'h0, nibble}, 16'h0000);
        paso();
        comprobar("wrap_listo", {15'h0, listo}, 16'h0001);
        comprobar("wrap_fin", {15'h0, fin_trama}, 16'h0001);
        comprobar("wrap_nib", {12'h0, nibble}, 16'h000F);
        comprobar("wrap_an", {12'h0, an}, 16'h000F);
        paso();
        comprobar("wrap1_listo", {15'h0, listo}, 16'h0000);
        comprobar("wrap1_fin", {15'h0, fin_trama}, 16'h0000);
        paso();
        revisar_trama("f1A2F", 16'h1A2F, AN_TODOS);

        // Load exactly on the wrap cycle (position 31).
        avanzar(5);
        dato   = 16'h00FF;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("onwrap_listo", {15'h0, listo}, 16'h0001);
        comprobar("onwrap_fin", {15'h0, fin_trama}, 16'h0001);
        comprobar("onwrap_nib", {12'h0, nibble}, 16'h000F);
        avanzar(2);
        revisar_trama("f00FF", 16'h00FF, AN_00FF);
        avanzar(6);
        comprobar("nopend_listo", {15'h0, listo}, 16'h0000);
        comprobar("nopend_fin", {15'h0, fin_trama}, 16'h0001);

        // Drop enable during digit 2's lit phase, load while idle.
        avanzar(18);
        comprobar("d2_an", {12'h0, an}, {12'h0, AN_D2_00FF});
        comprobar("d2_nib", {12'h0, nibble}, 16'h0000);
        habilitar = 1'b0;
        paso();
        comprobar("off_an", {12'h0, an}, 16'h000F);
        comprobar("off_nib_idx0", {12'h0, nibble}, 16'h000F);
        dato   = 16'h0003;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("idle_listo", {15'h0, listo}, 16'h0001);
        comprobar("idle_nib", {12'h0, nibble}, 16'h0003);
        habilitar = 1'b1;
        paso();
        comprobar("reen_listo", {15'h0, listo}, 16'h0000);
        comprobar("reen_an_guard", {12'h0, an}, 16'h000F);
        avanzar(2);
        comprobar("reen_an_d0", {12'h0, an}, 16'h000E);
        comprobar("reen_nib_d0", {12'h0, nibble}, 16'h0003);

        // Leading zeros: 0005.
        habilitar = 1'b0;
        paso();
        dato   = 16'h0005;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("l5_listo", {15'h0, listo}, 16'h0001);
        habilitar = 1'b1;
        avanzar(3);
        revisar_trama("f0005", 16'h0005, AN_0005);

        // All zero: digit 0 stays lit.
        habilitar = 1'b0;
        paso();
        dato   = 16'h0000;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("l0_listo", {15'h0, listo}, 16'h0001);
        habilitar = 1'b1;
        avanzar(3);
        comprobar("z_an_d0", {12'h0, an}, 16'h000E);
        comprobar("z_nib_d0", {12'h0, nibble}, 16'h0000);
        avanzar(8);
        comprobar("z_an_d1", {12'h0, an}, {12'h0, AN_D1_0000});

        // Reset with a load pending discards the load.
        dato   = 16'h1234;
        cargar = 1'b1;
        paso();
        cargar = 1'b0;
        comprobar("pend_listo", {15'h0, listo}, 16'h0000);
        rst = 1'b1;
        paso();
        comprobar("mrst_an", {12'h0, an}, 16'h000F);
        comprobar("mrst_nib", {12'h0, nibble}, 16'h0000);
        comprobar("mrst_listo", {15'h0, listo}, 16'h0000);
        comprobar("mrst_fin", {15'h0, fin_trama}, 16'h0000);
        rst = 1'b0;
        for (int unsigned c = 0; c < 34; c++) begin
            paso();
            comprobar($sformatf("post_listo_c%0d", c), {15'h0, listo}, 16'h0000);
            comprobar($sformatf("post_nib_c%0d", c), {12'h0, nibble}, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controlador_multiplexor_display.md
# controlador_multiplexor_display

Time-multiplexed scan controller that shares one binary-to-hex seven-segment decoder among `NUM_DIG` common-anode digits. Each cycle it presents one nibble to the decoder and drives the anode enables. A guard interval between digits prevents ghosting. A double-buffered load port commits new values only at frame boundaries, so the display never tears. It sits between the value-producing logic and the shared decoder/anode pins on the FPGA board.

## Interface
- `NUM_DIG`, 4: number of digits scanned; digit `NUM_DIG-1` is most significant.
- `DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD`, 16: blanked cycles at the start of each slot; range 0..`DIV-1`.

- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `habilitar` in 1: scan enable.
- `dato` in 4·`NUM_DIG`: value to display; nibble k drives digit k.
- `cargar` in 1: one-cycle strobe that captures `dato` into the shadow register.
- `nibble` out 4: digit code fed to the shared decoder.
- `an` out `NUM_DIG`: anode enables, active-low (0 = digit on).
- `listo` out 1: one-cycle pulse when the shadow value is committed to the display register.
- `fin_trama` out 1: one-cycle pulse on the last cycle of digit `NUM_DIG-1`.

## Operation
- Internal state:
  - `cnt`, 0..`DIV-1`: cycle counter within a slot.
  - `idx`, 0..`NUM_DIG-1`: current digit.
  - `sombra`: shadow register.
  - `pendiente`: load-pending flag.
  - `pantalla`: display register.
- States:
  - REPOSO: all anodes off; `cnt` = 0, `idx` = 0.
  - GUARDA: anodes off; `nibble` already shows `pantalla[idx]`.
  - ACTIVO: `an[idx]` = 0, all other anode bits 1.
- Transitions:
  - REPOSO → GUARDA when `habilitar` = 1. If `GUARD` = 0, go directly to ACTIVO.
  - GUARDA → ACTIVO when `cnt` = `GUARD-1`.
  - ACTIVO → GUARDA (or ACTIVO if `GUARD` = 0) when `cnt` = `DIV-1`. On this transition `cnt` → 0 and `idx` → `idx+1`, wrapping `NUM_DIG-1` → 0.
  - Any state → REPOSO on the cycle after `habilitar` = 0.
- Loading:
  - `cargar` = 1 → `sombra` ← `dato`, `pendiente` ← 1.
  - Commit happens at the wrap cycle (`idx` = `NUM_DIG-1`, `cnt` = `DIV-1`), or on any cycle while in REPOSO, if `pendiente` = 1. Commit does `pantalla` ← `sombra`, `pendiente` ← 0, and pulses `listo`.
  - If `cargar` coincides with a commit, `pantalla` ← `dato` directly, `pendiente` ← 0, and `listo` pulses.
  - If `cargar` repeats before a commit, the last captured value wins.
- `nibble` = `pantalla[4·idx+3 : 4·idx]` in every state. In REPOSO `idx` = 0.

## Timing
- All outputs are registered and update on the rising `clk` edge.
- Reset values: `an` all ones, `nibble` 0, `listo` 0, `fin_trama` 0. Internal: `pantalla`, `sombra`, `pendiente`, `cnt`, `idx` all 0; state REPOSO.
- `rst` mid-operation: reset values appear on the next edge; any pending load is discarded.
- Slot length is exactly `DIV` cycles: `GUARD` blanked cycles, then `DIV-GUARD` lit cycles. Frame length is `NUM_DIG`·`DIV` cycles.
- `fin_trama` and a commit-driven `listo` are asserted in the same cycle.
- `cargar`-to-visible latency while scanning is at most one frame plus `GUARD`+1 cycles. In REPOSO, `listo` follows `cargar` by one cycle.
- Dropping `habilitar` mid-slot: `an` = all ones on the next edge; scanning restarts at digit 0, `cnt` = 0 when re-enabled.

## Configuration
- Macro: `SUPRIMIR_CEROS_EN`.
- Defined: during ACTIVO, digit k > 0 keeps `an[k]` = 1 whenever all nibbles of `pantalla` from `NUM_DIG-1` down to k are zero. Digit 0 is always lit. Slot timing is unchanged.
- Undefined: every digit is lit in its slot, including leading zeros.

## Test plan
Parameters for all scenarios: `NUM_DIG`=4, `DIV`=8, `GUARD`=2.
- Reset, then `habilitar`=1 → `an`=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101; `nibble`=0 throughout.
- `cargar` with `dato`=16'h1A2F mid-frame → `pantalla` unchanged until the wrap; `listo` and `fin_trama` pulse together; next frame `nibble` sequence is F, 2, A, 1.
- `cargar` with `dato`=16'h00FF exactly on the wrap cycle → `listo`=1 that edge, `pendiente`=0, next frame shows F, F, 0, 0.
- `habilitar`=0 during ACTIVO of digit 2 → next cycle `an`=1111, `idx`=0. Then `cargar` 16'h0003 → `listo` one cycle later. Re-enable → digit 0 first, showing 3.
- `dato`=16'h0005 committed → with `SUPRIMIR_CEROS_EN` only `an[0]` is ever low. Without it, all four digits are lit, showing 5, 0, 0, 0. Also 16'h0000 with the macro → digit 0 still lit, showing 0.
- `rst`=1 during ACTIVO with `pendiente`=1 → next edge all reset values; no `listo` pulse afterwards.
